move_input_conditioner: RTL
===========================

Name: move_input_conditioner

Overview:
Upstream stage of the frog position tracker. It takes the four raw, asynchronous direction buttons and produces clean single-cycle move pulses on the game clock. Each button is synchronised and debounced, and an optional auto-repeat fires while a button is held. Simultaneous presses are arbitrated so at most one direction pulse is high per cycle. The outputs drive the tracker's Right/Up/Down/Left inputs directly, so a held button never moves the frog every clock.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive cycles a synchronised level must differ from the debounced level before it is accepted; legal range 1..255
REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives exactly one pulse per press
REPEAT_DELAY, 8, cycles from a press event to the first repeat event; legal range 1..255
REPEAT_PERIOD, 4, cycles between later repeat events; legal range 1..255

Ports:
clk  in  1  game clock; all state on the rising edge
reset  in  1  synchronous, active-high; one clock; clears all state
en  in  1  1 means game active; 0 suppresses and discards all move events
key_right, key_up, key_down, key_left  in  1 each  raw button levels, active-high, asynchronous
Right, Up, Down, Left  out  1 each  registered single-cycle move pulses; at most one high per cycle
move_valid  out  1  OR of the four pulse outputs, registered
held  out  4  debounced levels, ordered {right, up, down, left}

Behaviour:
- Reset values while reset is high at an edge:
  - sync flops, debounced levels, debounce and repeat counters, and pending bits = 0
  - all FSMs in RELEASED
  - Right/Up/Down/Left/move_valid = 0; held = 0
- Per-key synchroniser: 2 flops, so q2 follows raw with 2-edge latency.
- Per-key debounce:
  - counter increments on each edge where q2 != debounced level
  - counter clears to 0 on any edge where q2 == debounced level, which rejects glitches
  - when the counter would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears
  - counter width is 8 bits
- Per-key FSM, driven by the debounced level:
  - RELEASED: on debounced rise, raise one press event and go to DELAY with rcnt = 0
  - DELAY: rcnt increments each cycle; when rcnt reaches REPEAT_DELAY-1 and REPEAT_EN = 1, raise an event and go to REPEAT with rcnt = 0
  - REPEAT: same as DELAY but uses REPEAT_PERIOD-1 and stays in REPEAT
  - REPEAT_EN = 0: stay in DELAY with rcnt saturated
  - any state: on debounced fall, go to RELEASED on that edge, with no event and no pulse
- Pending set: 4 bits, one per key.
  - an event sets its key's bit; an event for an already-pending key merges and does not queue twice
- Arbitration, every edge with en = 1:
  - priority is Right > Up > Down > Left
  - the highest-priority pending bit drives its output high for the next cycle, and that bit is cleared
  - all other pulse outputs are 0
  - if the granted bit is cleared on the same edge as a new event for that key, the bit stays set
- Latency: raw held high and first sampled at edge 0, no contention, en = 1:
  - debounced rise at edge D+1, where D = DEBOUNCE_CYCLES
  - pulse high after edge D+2, for exactly one cycle
- en = 0:
  - outputs forced to 0 at the next edge
  - pending cleared
  - events raised that cycle are discarded
  - synchronisers, debounce and FSMs keep running, so a held key resumes repeating on its own schedule after en returns
- Release and re-press: a new press event needs a debounced fall followed by a debounced rise.
- Reset mid-press: after reset deasserts with the key still held, it is treated as a fresh press and pulses after D+2 edges.

Test Plan:
- Single press, defaults, REPEAT_EN = 0: key_up high for 20 cycles -> Up pulses once, after edge 5, width 1 cycle; move_valid mirrors it; held[2] = 1 from edge 4; no further pulses.
- Glitch rejection: key_left high for 2 cycles, then low -> no pulse, held stays 0; a 3-cycle high at the synchroniser output is accepted.
- Auto-repeat, defaults: key_right held 40 cycles -> Right pulses after edges 5, 13, 17, 21, 25, … (period 4); release -> pulses stop within D+2 cycles.
- Simultaneous press: key_up and key_left rise on the same edge -> Up after edge 5, Left after edge 6; never two outputs high in one cycle.
- Enable gating: hold key_down with en = 0 -> no pulses; raise en mid-hold -> next Down pulse lands on the existing repeat schedule.
- Reset mid-hold: key_right held, reset pulsed at cycle 10 for 1 cycle -> all outputs 0 during reset; fresh Right pulse 5 edges after reset deasserts.

Source files
------------

// File: rtl/move_input_conditioner.sv
// move_input_conditioner
//
// Front end of the frog position tracker. Turns the four raw, asynchronous
// direction buttons into clean single-cycle move pulses on the game clock.
// Each button is synchronised, debounced and run through a small press /
// auto-repeat state machine. Events from all four keys collect in a pending
// set, and a fixed-priority arbiter (Right > Up > Down > Left) releases at
// most one of them per cycle. A held button therefore moves the frog once
// per press, plus the optional repeats, and never once per clock.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new synchronised level must persist (1..255)
//   REPEAT_EN        1 = auto-repeat while held, 0 = one pulse per press
//   REPEAT_DELAY     cycles from the press event to the first repeat (1..255)
//   REPEAT_PERIOD    cycles between later repeats (1..255)
//
// Ports:
//   clk                    game clock, all state on the rising edge
//   reset                  synchronous, active-high, clears all state
//   en                     1 = game active; 0 suppresses and discards moves
//   key_right/up/down/left raw active-high button levels (asynchronous)
//   Right/Up/Down/Left     registered single-cycle move pulses, one-hot or 0
//   move_valid             registered OR of the four pulses
//   held                   debounced levels, ordered {right, up, down, left}

module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    output logic       Right,
    output logic       Up,
    output logic       Down,
    output logic       Left,
    output logic       move_valid,
    output logic [3:0] held
);

    localparam logic [1:0] RELEASED = 2'd0;
    localparam logic [1:0] DELAY    = 2'd1;
    localparam logic [1:0] REPEAT   = 2'd2;

    // Terminal counts: the counter value on the edge that completes the run.
    localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] DELAY_LAST = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] PERIOD_LAST = 8'(REPEAT_PERIOD - 1);
    localparam bit         REPEAT_ON  = (REPEAT_EN != 0);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] event_v;
    logic [3:0] pending;
    logic [3:0] grant;
    logic [3:0] pulse;

    assign raw = {key_right, key_up, key_down, key_left};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_key
            logic       q1;
            logic       q2;
            logic       deb;
            logic [7:0] dcnt;
            logic [1:0] state;
            logic [7:0] rcnt;
            logic       rise;
            logic       fall;
            logic       ev;

            // The debounced level flips on this edge. The state machine
            // reacts to the flip in the same edge, so the press event lands
            // in the pending set together with the new held level.
            assign rise = q2 && !deb && (dcnt == DB_LAST);
            assign fall = !q2 && deb && (dcnt == DB_LAST);

            // Two-flop synchroniser, followed by a run-length debounce.
            // Any edge that agrees with the current debounced level restarts
            // the run, so short glitches never accumulate.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q1   <= 1'b0;
                    q2   <= 1'b0;
                    deb  <= 1'b0;
                    dcnt <= 8'd0;
                end else begin
                    q1 <= raw[i];
                    q2 <= q1;
                    if (q2 == deb) begin
                        dcnt <= 8'd0;
                    end else if (dcnt == DB_LAST) begin
                        deb  <= q2;
                        dcnt <= 8'd0;
                    end else begin
                        dcnt <= dcnt + 8'd1;
                    end
                end
            end

            // Move events: one on the press, then timed repeats while held.
            // A release wins over a repeat that falls due on the same edge.
            always_comb begin
                ev = 1'b0;
                if (!fall) begin
                    case (state)
                        RELEASED: ev = rise;
                        DELAY:    ev = REPEAT_ON && (rcnt == DELAY_LAST);
                        REPEAT:   ev = (rcnt == PERIOD_LAST);
                        default:  ev = 1'b0;
                    endcase
                end
            end

            // Press / repeat state machine. With repeat disabled the delay
            // counter parks at its terminal count until the key is released.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state <= RELEASED;
                    rcnt  <= 8'd0;
                end else if (fall) begin
                    state <= RELEASED;
                    rcnt  <= 8'd0;
                end else begin
                    case (state)
                        RELEASED: begin
                            rcnt <= 8'd0;
                            if (rise) begin
                                state <= DELAY;
                            end
                        end
                        DELAY: begin
                            if (rcnt == DELAY_LAST) begin
                                if (REPEAT_ON) begin
                                    state <= REPEAT;
                                    rcnt  <= 8'd0;
                                end
                            end else begin
                                rcnt <= rcnt + 8'd1;
                            end
                        end
                        REPEAT: begin
                            if (rcnt == PERIOD_LAST) begin
                                rcnt <= 8'd0;
                            end else begin
                                rcnt <= rcnt + 8'd1;
                            end
                        end
                        default: begin
                            state <= RELEASED;
                            rcnt  <= 8'd0;
                        end
                    endcase
                end
            end

            assign level[i]   = deb;
            assign event_v[i] = ev;
        end
    endgenerate

    // Fixed priority among the already-pending moves.
    always_comb begin
        grant = 4'b0000;
        if (pending[3]) begin
            grant = 4'b1000;
        end else if (pending[2]) begin
            grant = 4'b0100;
        end else if (pending[1]) begin
            grant = 4'b0010;
        end else if (pending[0]) begin
            grant = 4'b0001;
        end
    end

    // Pending set and pulse register. New events are ORed in after the
    // granted bit is cleared, so an event arriving on the grant edge is kept
    // and a second event for a waiting key simply merges. While the game is
    // paused everything queued, and anything raised that cycle, is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 4'b0000;
            pulse      <= 4'b0000;
            move_valid <= 1'b0;
        end else if (!en) begin
            pending    <= 4'b0000;
            pulse      <= 4'b0000;
            move_valid <= 1'b0;
        end else begin
            pending    <= (pending & ~grant) | event_v;
            pulse      <= grant;
            move_valid <= |grant;
        end
    end

    assign Right = pulse[3];
    assign Up    = pulse[2];
    assign Down  = pulse[1];
    assign Left  = pulse[0];
    assign held  = level;

endmodule
